// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers.
// One result bit per cycle; MULT/MULTU/DIV/DIVU plus MTHI/MTLO.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [1:0]            op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic                  flush_i,
  input  logic                  mthi_i,
  input  logic                  mtlo_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] hi_o,
  output logic [DATA_WIDTH-1:0] lo_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  div_by_zero_o
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIXUP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic          w_accept;
  logic          w_commit;
  logic          w_last;
  logic          w_mt_ok;

  logic          r_div;
  logic          r_neg_q;
  logic          r_neg_r;
  logic          r_dbz_pend;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_m;
  logic [W-1:0]  r_orig;
  logic [2*W-1:0] r_acc;
  logic [W-1:0]  r_hi;
  logic [W-1:0]  r_lo;
  logic          r_done;
  logic          r_dbz;

  logic          w_signed;
  logic          w_sa;
  logic          w_sb;
  logic [W-1:0]  w_mag_a;
  logic [W-1:0]  w_mag_b;

  logic [W:0]     w_mul_sum;
  logic [2*W-1:0] w_mul_next;
  logic [W:0]     w_div_sh;
  logic [W:0]     w_div_diff;
  logic [2*W-1:0] w_div_next;

  logic [2*W-1:0] w_prod;
  logic [W-1:0]   w_quo;
  logic [W-1:0]   w_rem;

  // Signed ops work on magnitudes; the most-negative value
  // negates to itself, which is its correct unsigned magnitude.
  assign w_signed = ~op_i[0];
  assign w_sa     = w_signed & a_i[W-1];
  assign w_sb     = w_signed & b_i[W-1];
  assign w_mag_a  = w_sa ? (~a_i + 1'b1) : a_i;
  assign w_mag_b  = w_sb ? (~b_i + 1'b1) : b_i;

  // Multiply: acc = {partial, multiplier}, add then shift right.
  assign w_mul_sum  = {1'b0, r_acc[2*W-1:W]}
                    + {1'b0, (r_acc[0] ? r_m : {W{1'b0}})};
  assign w_mul_next = {w_mul_sum, r_acc[W-1:1]};

  // Divide: acc = {remainder, quotient}, restoring step.
  assign w_div_sh   = r_acc[2*W-1:W-1];
  assign w_div_diff = w_div_sh - {1'b0, r_m};
  assign w_div_next = w_div_diff[W]
    ? {w_div_sh[W-1:0], r_acc[W-2:0], 1'b0}
    : {w_div_diff[W-1:0], r_acc[W-2:0], 1'b1};

  assign w_prod = r_neg_q ? (~r_acc + 1'b1) : r_acc;
  assign w_quo  = r_neg_q ? (~r_acc[W-1:0] + 1'b1)
                          : r_acc[W-1:0];
  assign w_rem  = r_neg_r ? (~r_acc[2*W-1:W] + 1'b1)
                          : r_acc[2*W-1:W];

  assign w_last  = (r_cnt == LAST);
  assign w_mt_ok = (r_state == S_IDLE) & ~start_i & ~flush_i;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic plus accept/commit strobes.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_commit = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i && !flush_i) begin
          w_next   = S_CALC;
          w_accept = 1'b1;
        end
      end
      S_CALC: begin
        if (flush_i)     w_next = S_IDLE;
        else if (w_last) w_next = S_FIXUP;
      end
      S_FIXUP: begin
        w_next   = S_IDLE;
        w_commit = ~flush_i;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operand latch and iterative datapath.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div      <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_dbz_pend <= 1'b0;
      r_cnt      <= '0;
      r_m        <= '0;
      r_orig     <= '0;
      r_acc      <= '0;
    end else if (w_accept) begin
      r_div      <= op_i[1];
      r_neg_q    <= w_sa ^ w_sb;
      r_neg_r    <= w_sa;
      r_dbz_pend <= op_i[1] & (b_i == '0);
      r_cnt      <= '0;
      r_orig     <= a_i;
      if (op_i[1]) begin
        r_m   <= w_mag_b;
        r_acc <= {{W{1'b0}}, w_mag_a};
      end else begin
        r_m   <= w_mag_a;
        r_acc <= {{W{1'b0}}, w_mag_b};
      end
    end else if (r_state == S_CALC && !flush_i) begin
      r_acc <= r_div ? w_div_next : w_mul_next;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // HI/LO write-back, MTHI/MTLO, and the done pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
    end else begin
      r_done <= w_commit;
      r_dbz  <= w_commit & r_dbz_pend;
      if (w_commit) begin
        if (!r_div) begin
          {r_hi, r_lo} <= w_prod;
        end else if (r_dbz_pend) begin
          r_hi <= r_orig;
          r_lo <= '1;
        end else begin
          r_hi <= w_rem;
          r_lo <= w_quo;
        end
      end else if (w_mt_ok) begin
        if (mthi_i) r_hi <= wdata_i;
        if (mtlo_i) r_lo <= wdata_i;
      end
    end
  end

  assign hi_o          = r_hi;
  assign lo_o          = r_lo;
  assign busy_o        = (r_state != S_IDLE);
  assign done_o        = r_done;
  assign div_by_zero_o = r_dbz;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at W=32 and W=8.
// Inputs change and outputs are sampled on the falling edge.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start32, start8;
  logic [1:0]  op_r;
  logic [31:0] a_r, b_r;
  logic        flush, mthi, mtlo;
  logic [31:0] wdata;

  logic [31:0] hi32, lo32;
  logic        busy32, done32, dbz32;
  logic [7:0]  hi8, lo8;
  logic        busy8, done8, dbz8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.DATA_WIDTH(32)) u32 (
    .clk(clk), .reset(reset),
    .start_i(start32), .op_i(op_r),
    .a_i(a_r), .b_i(b_r),
    .flush_i(flush), .mthi_i(mthi), .mtlo_i(mtlo),
    .wdata_i(wdata),
    .hi_o(hi32), .lo_o(lo32),
    .busy_o(busy32), .done_o(done32),
    .div_by_zero_o(dbz32)
  );

  muldiv_unit #(.DATA_WIDTH(8)) u8 (
    .clk(clk), .reset(reset),
    .start_i(start8), .op_i(op_r),
    .a_i(a_r[7:0]), .b_i(b_r[7:0]),
    .flush_i(1'b0), .mthi_i(1'b0), .mtlo_i(1'b0),
    .wdata_i(8'h00),
    .hi_o(hi8), .lo_o(lo8),
    .busy_o(busy8), .done_o(done8),
    .div_by_zero_o(dbz8)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Issue one op, measure busy length, check the result.
  // Returns on the done cycle so the next call is back-to-back.
  task automatic do_op(input bit w8,
                       input logic [1:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [31:0] exp_hi,
                       input logic [31:0] exp_lo,
                       input logic exp_dbz,
                       input string tag);
    int n;
    op_r = op;
    a_r  = a;
    b_r  = b;
    if (w8) start8 = 1'b1;
    else    start32 = 1'b1;
    @(negedge clk);
    start8  = 1'b0;
    start32 = 1'b0;
    chk({tag, ".done_low"},
        {31'b0, (w8 ? done8 : done32)}, 32'd0);
    n = 0;
    while ((w8 ? busy8 : busy32) && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk({tag, ".lat"}, n, w8 ? 32'd9 : 32'd33);
    chk({tag, ".hi"},
        w8 ? {24'b0, hi8} : hi32, exp_hi);
    chk({tag, ".lo"},
        w8 ? {24'b0, lo8} : lo32, exp_lo);
    chk({tag, ".done"},
        {31'b0, (w8 ? done8 : done32)}, 32'd1);
    chk({tag, ".dbz"},
        {31'b0, (w8 ? dbz8 : dbz32)}, {31'b0, exp_dbz});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int dn;
    reset   = 1'b0;
    start32 = 1'b0;
    start8  = 1'b0;
    op_r    = 2'b00;
    a_r     = '0;
    b_r     = '0;
    flush   = 1'b0;
    mthi    = 1'b0;
    mtlo    = 1'b0;
    wdata   = '0;
    repeat (3) @(negedge clk);
    chk("rst.hi",   hi32, 32'd0);
    chk("rst.lo",   lo32, 32'd0);
    chk("rst.busy", {31'b0, busy32}, 32'd0);
    chk("rst.done", {31'b0, done32}, 32'd0);
    chk("rst.dbz",  {31'b0, dbz32}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    do_op(0, 2'b00, 32'hFFFFFFFF, 32'd7,
          32'hFFFFFFFF, 32'hFFFFFFF9, 0, "t1_mult");
    @(negedge clk);
    chk("t1.pulse", {31'b0, done32}, 32'd0);

    do_op(0, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF,
          32'hFFFFFFFE, 32'h00000001, 0, "t2_multu");
    do_op(0, 2'b00, 32'd3, 32'hFFFFFFFB,
          32'hFFFFFFFF, 32'hFFFFFFF1, 0, "t2_b2b");

    do_op(0, 2'b10, 32'hFFFFFFF9, 32'd2,
          32'hFFFFFFFF, 32'hFFFFFFFD, 0, "t3_div_na");
    do_op(0, 2'b10, 32'd7, 32'hFFFFFFFE,
          32'h00000001, 32'hFFFFFFFD, 0, "t3_div_nb");
    do_op(0, 2'b11, 32'd7, 32'd2,
          32'd1, 32'd3, 0, "t3_divu");

    do_op(0, 2'b10, 32'h80000000, 32'hFFFFFFFF,
          32'h0, 32'h80000000, 0, "t4_ovf");
    do_op(0, 2'b11, 32'd5, 32'd0,
          32'd5, 32'hFFFFFFFF, 1, "t4_divu0");
    do_op(0, 2'b10, 32'hFFFFFFFB, 32'd0,
          32'hFFFFFFFB, 32'hFFFFFFFF, 1, "t4_div0");
    @(negedge clk);
    chk("t4.dbz_pulse", {31'b0, dbz32}, 32'd0);

    mthi  = 1'b1;
    mtlo  = 1'b1;
    wdata = 32'hABCD;
    @(negedge clk);
    chk("t5.both_hi", hi32, 32'hABCD);
    chk("t5.both_lo", lo32, 32'hABCD);
    mtlo  = 1'b0;
    wdata = 32'h1234;
    @(negedge clk);
    mthi  = 1'b0;
    mtlo  = 1'b1;
    wdata = 32'h5678;
    @(negedge clk);
    mtlo  = 1'b0;
    chk("t5.mthi", hi32, 32'h1234);
    chk("t5.mtlo", lo32, 32'h5678);

    op_r    = 2'b00;
    a_r     = 32'd2;
    b_r     = 32'd3;
    start32 = 1'b1;
    @(negedge clk);
    for (int i = 1; i < 10; i++) begin
      start32 = (i == 3);
      mthi    = (i == 3);
      wdata   = 32'hDEAD;
      @(negedge clk);
    end
    start32 = 1'b0;
    mthi    = 1'b0;
    flush   = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("t5.flush_busy", {31'b0, busy32}, 32'd0);
    chk("t5.busy_mthi", hi32, 32'h1234);
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      dn += int'(done32);
      @(negedge clk);
    end
    chk("t5.no_done", dn, 32'd0);
    chk("t5.no_queue", {31'b0, busy32}, 32'd0);
    chk("t5.hi", hi32, 32'h1234);
    chk("t5.lo", lo32, 32'h5678);

    start32 = 1'b1;
    flush   = 1'b1;
    mthi    = 1'b1;
    wdata   = 32'hFFFF;
    @(negedge clk);
    start32 = 1'b0;
    flush   = 1'b0;
    mthi    = 1'b0;
    chk("t5.idle_flush", {31'b0, busy32}, 32'd0);
    chk("t5.flush_mthi", hi32, 32'h1234);

    op_r    = 2'b10;
    a_r     = 32'd100;
    b_r     = 32'd7;
    start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    chk("t6.busy_pre", {31'b0, busy32}, 32'd1);
    repeat (19) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t6.hi",   hi32, 32'd0);
    chk("t6.lo",   lo32, 32'd0);
    chk("t6.busy", {31'b0, busy32}, 32'd0);
    chk("t6.done", {31'b0, done32}, 32'd0);
    chk("t6.dbz",  {31'b0, dbz32}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    do_op(1, 2'b00, 32'hFF, 32'h07,
          32'hFF, 32'hF9, 0, "w8_mult");
    do_op(1, 2'b10, 32'hF9, 32'h02,
          32'hFF, 32'hFD, 0, "w8_div_na");
    do_op(1, 2'b10, 32'h07, 32'hFE,
          32'h01, 32'hFD, 0, "w8_div_nb");
    do_op(1, 2'b11, 32'h07, 32'h02,
          32'h01, 32'h03, 0, "w8_divu");

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit with architectural HI/LO registers. It implements MULT, MULTU, DIV, DIVU, MTHI and MTLO for the pipelined MIPS core. It sits beside the ALU in the EX stage. While busy it stalls the pipeline through `busy_o`, and a MEM-stage branch/jump redirect aborts it through `flush_i`.

## Interface
- `DATA_WIDTH`, 32: operand and HI/LO width; any value ≥ 4.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `start_i` in 1: request a new operation. Sampled only in IDLE.
- `op_i` in 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU. Sampled with `start_i`.
- `a_i` in DATA_WIDTH: multiplicand / dividend (rs).
- `b_i` in DATA_WIDTH: multiplier / divisor (rt).
- `flush_i` in 1: abort any in-flight operation; discard `start_i` in the same cycle.
- `mthi_i` in 1: write `wdata_i` to HI.
- `mtlo_i` in 1: write `wdata_i` to LO.
- `wdata_i` in DATA_WIDTH: data for MTHI/MTLO.
- `hi_o` out DATA_WIDTH: HI register (MFHI source).
- `lo_o` out DATA_WIDTH: LO register (MFLO source).
- `busy_o` out 1: high in CALC and FIXUP.
- `done_o` out 1: one-cycle pulse in the cycle after HI/LO are written.
- `div_by_zero_o` out 1: pulses together with `done_o` when a DIV/DIVU had `b_i == 0`.

## Operation
- **States:** IDLE, CALC, FIXUP.
- **IDLE → CALC:** on `start_i & ~flush_i`.
  - Latch `op_i`.
  - Latch the operand magnitudes. Signed ops take the absolute value; the most-negative value maps to its unsigned magnitude 2^(W-1).
  - Latch the result signs: product sign = sign(a) XOR sign(b); quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - Clear the bit counter.
- **CALC:** processes one bit per cycle for exactly DATA_WIDTH cycles, then goes to FIXUP.
  - Multiply: shift-add, 2W-bit unsigned accumulator.
  - Divide: restoring division, W-bit remainder plus W-bit quotient.
- **FIXUP → IDLE:**
  - Negate the results where the signs require it.
  - Write HI/LO. Multiply: {HI,LO} = 2W-bit product. Divide: LO = quotient (truncated toward zero), HI = remainder.
  - Set `done_o` for the next cycle.
- **Divide by zero** (`b_i == 0`, signed or unsigned): LO = all ones, HI = original `a_i` unmodified, `div_by_zero_o` pulses with `done_o`.
- **Signed overflow** (most-negative ÷ -1): LO = most-negative value, HI = 0. No flag.
- **flush_i in CALC or FIXUP:** next state is IDLE. HI/LO are not written and neither `done_o` nor `div_by_zero_o` pulses.
- **MTHI/MTLO:** write on the clock edge only when the state is IDLE, `start_i` is low and `flush_i` is low. Both may be asserted together. They are ignored otherwise.
- **start_i during CALC/FIXUP:** ignored. No queuing.
- **hi_o/lo_o:** always reflect the registers. During busy they hold the previous results.

## Timing
- **Reset values:** HI = 0, LO = 0, `busy_o` = 0, `done_o` = 0, `div_by_zero_o` = 0, state IDLE, counter 0.
- **Reset mid-operation:** returns immediately to all reset values. No partial write.
- **Start:** accepted at edge E0. `busy_o` is high from E0 until edge E0+W+1.
- **Result:** HI/LO are written at edge E0+W+1. At that same edge `busy_o` falls and `done_o`/`div_by_zero_o` rise for one cycle.
- **Latency:** W+1 cycles (33 for W=32).
- **Back-to-back:** a new `start_i` may be accepted in the `done_o` cycle (IDLE). Its operands may be the just-written `hi_o`/`lo_o`.
- **Flush:** `flush_i` high at edge Ef returns the state to IDLE, with `busy_o` low after Ef.

## Test plan
1. MULT a=0xFFFFFFFF (-1), b=7, W=32 → `busy_o` high for 33 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF9, single `done_o` pulse.
2. MULTU a=b=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. Back-to-back MULT 3×-5 issued in the done cycle → HI=0xFFFFFFFF, LO=0xFFFFFFF1.
3. DIV -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 7/-2 → LO=0xFFFFFFFD, HI=0x00000001. DIVU 7/2 → LO=3, HI=1.
4. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0, `div_by_zero_o` low. DIVU 5/0 → LO=0xFFFFFFFF, HI=5, `div_by_zero_o` pulses with `done_o`.
5. Preload MTHI=0x1234, MTLO=0x5678; start MULT; assert `flush_i` at cycle 10 → `busy_o` low next cycle, HI=0x1234, LO=0x5678, no `done_o`. A second `start_i` during busy is ignored. MTHI during busy is ignored.
6. Assert `reset` low at cycle 20 of a DIV → all outputs 0 immediately. Repeat tests 1 and 3 with DATA_WIDTH=8 (-1×7 → HI=0xFF, LO=0xF9, latency 9).
